// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between the CDDA
// fetcher, the IDE sector engine and the AVR external-SRAM window.
module sram_arbiter #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] cpu_a_i,
  input  logic [DW-1:0] cpu_d_in_i,
  output logic [DW-1:0] cpu_d_out_o,
  input  logic          cpu_cs_i,
  input  logic          cpu_oe_i,
  input  logic          cpu_we_i,
  output logic          cpu_wait_o,
  input  logic          ide_req_i,
  input  logic          cdda_req_i,
  input  logic          ide_we_i,
  input  logic          cdda_we_i,
  input  logic [AW-1:0] ide_a_i,
  input  logic [AW-1:0] cdda_a_i,
  input  logic [DW-1:0] ide_wd_i,
  input  logic [DW-1:0] cdda_wd_i,
  output logic          ide_gnt_o,
  output logic          cdda_gnt_o,
  output logic          ide_rvalid_o,
  output logic          cdda_rvalid_o,
  output logic [DW-1:0] ide_rd_o,
  output logic [DW-1:0] cdda_rd_o,
  output logic [AW-1:0] ram_a_o,
  output logic [DW-1:0] ram_d_o,
  output logic          ram_we_o,
  output logic          ram_en_o,
  input  logic [DW-1:0] ram_q_i
);

  localparam logic [1:0] IDX_CDDA = 2'd0;
  localparam logic [1:0] IDX_IDE  = 2'd1;
  localparam logic [1:0] IDX_CPU  = 2'd2;

  typedef enum logic [1:0] {
    CPU_IDLE   = 2'd0,
    CPU_ISSUED = 2'd1,
    CPU_DONE   = 2'd2
  } cpu_state_e;

  cpu_state_e    cpu_state_q;
  logic [DW-1:0] cpu_d_out_q;
  logic [1:0]    last_q, last_d;
  logic          pipe_vld_q, pipe_vld_d;
  logic [1:0]    pipe_tag_q, pipe_tag_d;

  logic          cpu_acc_s;
  logic [3:0]    pend_s;
  logic [1:0]    cand1_s, cand2_s;
  logic          win_vld_s;
  logic [1:0]    win_s;
  logic          win_we_s;
  logic [AW-1:0] win_a_s;
  logic [DW-1:0] win_d_s;
  logic          cpu_gnt_s;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  assign cpu_acc_s = cpu_cs_i & (cpu_oe_i | cpu_we_i);
  // The CPU may only issue once per strobe assertion, i.e. from IDLE.
  assign pend_s    = {1'b0, cpu_acc_s & (cpu_state_q == CPU_IDLE), ide_req_i, cdda_req_i};
  assign cand1_s   = next_idx(last_q);
  assign cand2_s   = next_idx(cand1_s);

  always_comb begin
    win_vld_s = 1'b1;
    win_s     = last_q;
    if (pend_s[cand1_s]) begin
      win_s = cand1_s;
    end else if (pend_s[cand2_s]) begin
      win_s = cand2_s;
    end else if (pend_s[last_q]) begin
      win_s = last_q;
    end else begin
      win_vld_s = 1'b0;
    end
  end

  always_comb begin
    win_we_s = 1'b0;
    win_a_s  = '0;
    win_d_s  = '0;
    case (win_s)
      IDX_CDDA: begin
        win_we_s = cdda_we_i;
        win_a_s  = cdda_a_i;
        win_d_s  = cdda_wd_i;
      end
      IDX_IDE: begin
        win_we_s = ide_we_i;
        win_a_s  = ide_a_i;
        win_d_s  = ide_wd_i;
      end
      IDX_CPU: begin
        win_we_s = cpu_we_i;
        win_a_s  = cpu_a_i;
        win_d_s  = cpu_d_in_i;
      end
      default: begin
        win_we_s = 1'b0;
        win_a_s  = '0;
        win_d_s  = '0;
      end
    endcase
  end

  assign cdda_gnt_o = win_vld_s & (win_s == IDX_CDDA);
  assign ide_gnt_o  = win_vld_s & (win_s == IDX_IDE);
  assign cpu_gnt_s  = win_vld_s & (win_s == IDX_CPU);

  assign ram_en_o = win_vld_s;
  assign ram_we_o = win_vld_s & win_we_s;
  assign ram_a_o  = win_a_s;
  assign ram_d_o  = win_d_s;

  always_comb begin
    last_d     = win_vld_s ? win_s : last_q;
    pipe_vld_d = win_vld_s & ~win_we_s;
    pipe_tag_d = win_s;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q     <= IDX_CPU;
      pipe_vld_q <= 1'b0;
      pipe_tag_q <= IDX_CDDA;
    end else begin
      last_q     <= last_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_tag_q <= pipe_tag_d;
    end
  end

  // CPU access sequencing; ISSUED is the cycle in which ram_q holds CPU read data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cpu_state_q <= CPU_IDLE;
      cpu_d_out_q <= '0;
    end else begin
      case (cpu_state_q)
        CPU_IDLE: begin
          if (cpu_gnt_s) begin
            cpu_state_q <= CPU_ISSUED;
          end
        end
        CPU_ISSUED: begin
          cpu_state_q <= CPU_DONE;
          if (pipe_vld_q && (pipe_tag_q == IDX_CPU)) begin
            cpu_d_out_q <= ram_q_i;
          end
        end
        CPU_DONE: begin
          if (!cpu_acc_s) begin
            cpu_state_q <= CPU_IDLE;
          end
        end
        default: cpu_state_q <= CPU_IDLE;
      endcase
    end
  end

  assign cpu_wait_o  = ((cpu_state_q == CPU_IDLE) & cpu_acc_s) | (cpu_state_q == CPU_ISSUED);
  assign cpu_d_out_o = cpu_d_out_q;

  assign cdda_rvalid_o = pipe_vld_q & (pipe_tag_q == IDX_CDDA);
  assign ide_rvalid_o  = pipe_vld_q & (pipe_tag_q == IDX_IDE);
  assign cdda_rd_o     = cdda_rvalid_o ? ram_q_i : '0;
  assign ide_rd_o      = ide_rvalid_o ? ram_q_i : '0;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Three-way arbiter for the single-port 4 KiB buffer RAM shared by the AVR external-SRAM window, the IDE sector buffer engine and the CDDA sample fetcher. Issues at most one RAM access per `clk` cycle, selects among pending requesters round-robin, and returns read data one cycle after issue. The AVR port keeps the CPU's `sram_cs/oe/we/wait` semantics; the IDE and CDDA ports use a req/gnt/rvalid handshake.

## Interface
- `AW`, 12, RAM address width (words)
- `DW`, 8, data width
- `clk`  in  1  system clock (CPU×4 domain)
- `rst`  in  1  asynchronous, active-high reset
- `cpu_a`  in  AW  CPU address
- `cpu_d_in`  in  DW  CPU write data
- `cpu_d_out`  out  DW  CPU read data, held until the next CPU read completes
- `cpu_cs`, `cpu_oe`, `cpu_we`  in  1  CPU strobes; access requested when `cpu_cs & (cpu_oe | cpu_we)`
- `cpu_wait`  out  1  stall CPU
- `ide_req`, `cdda_req`  in  1  request; held with addr/we/wdata until granted
- `ide_we`, `cdda_we`  in  1  write enable
- `ide_a`, `cdda_a`  in  AW  address
- `ide_wd`, `cdda_wd`  in  DW  write data
- `ide_gnt`, `cdda_gnt`  out  1  one-cycle pulse: request issued this cycle
- `ide_rvalid`, `cdda_rvalid`  out  1  one-cycle pulse: `ram_q` read data valid
- `ide_rd`, `cdda_rd`  out  DW  read data (registered `ram_q`)
- `ram_a`  out  AW, `ram_d`  out  DW, `ram_we`  out  1, `ram_en`  out  1  RAM port (synchronous, 1-cycle read latency)
- `ram_q`  in  DW  RAM read data

## Operation
- Requesters indexed 0 = CDDA, 1 = IDE, 2 = CPU. Round-robin pointer `last` (2 bits, 0..2) holds the most recently granted index.
- Each cycle: scan indices `last+1, last+2, last+3` (mod 3); the first pending one wins. Grant is combinational from the pending set and registered `last`; RAM outputs (`ram_en/ram_a/ram_d/ram_we`) are driven combinationally from the winner in the same cycle; `last` updates on the clock edge.
- Pending: CDDA/IDE = `*_req`; CPU = CPU access requested and `cpu_done == 0`.
- CPU FSM, states IDLE, ISSUED, DONE:
  - IDLE: CPU access requested -> `cpu_wait = 1`; on grant -> ISSUED.
  - ISSUED: `cpu_wait = 1`; read latches `ram_q` into `cpu_d_out`; -> DONE.
  - DONE: `cpu_wait = 0`, `cpu_done = 1`; when the access request drops -> IDLE.
  - Writes follow the same path, so the CPU always sees ≥2 wait cycles.
- The read-return pipeline holds a 2-bit tag of the issuing requester plus a valid bit. The matching `*_rvalid` pulses in the cycle after issue, with data in `*_rd` (IDE/CDDA). Writes produce no rvalid.
- No address decoding: the system-level window select (`sram_a[11]`) is applied outside this block.
- Write data and address are taken from the winner in the grant cycle; requesters may change them the cycle after `gnt`.

## Timing
- Reset values: `last = 2` (CDDA first), CPU FSM IDLE, all `gnt`/`rvalid`/`ram_en`/`ram_we`/`cpu_wait` = 0, `cpu_d_out`/`*_rd` = 0.
- Grant latency: 0 cycles when the requester is alone. Worst case with all three saturating: 2 cycles between request and grant. Each requester gets one slot per 3 cycles.
- Read latency: `gnt` in cycle N, `rvalid` and data in cycle N+1.
- A requester that keeps `req` high after `gnt` issues a new access; back-to-back grants occur only when no other requester is pending.
- A CPU request that drops before it is granted is discarded: return to IDLE, no RAM access.
- Reset asserted mid-operation: the in-flight pipeline tag is cleared, so no rvalid follows; the FSM returns to IDLE.
- A write and a read to the same address in consecutive slots: the read returns the new data (RAM is read-after-write across cycles).

## Test plan
- Only IDE reads addr 0x123 (RAM preloaded 0x5A) -> `ide_gnt` in the same cycle, `ide_rvalid` with `ide_rd = 0x5A` next cycle, `cpu_wait` stays 0.
- All three request continuously out of reset -> grant order CDDA, IDE, CPU, CDDA, IDE…; each requester is granted exactly every 3rd cycle.
- CPU writes 0xA5 to 0x800, then reads it -> `cpu_wait` high for 2 cycles on each access; the read returns `cpu_d_out = 0xA5`.
- CDDA writes 0x11 to 0x010 while IDE reads 0x010 in the next slot -> `ide_rd = 0x11`.
- CPU request dropped while IDE and CDDA hold the RAM -> no CPU RAM access issued, FSM returns to IDLE, `cpu_wait` falls.
- `rst` asserted in the cycle after an IDE read grant -> no `ide_rvalid`, all outputs at reset values, and the first grant after release goes to CDDA.
